spike_rate_decoder: RTL and testbench



---
 rtl/spike_rate_if.sv | 14 +
 rtl/spike_rate_decoder.sv | 117 +++++++++++
 tb/tb_spike_rate_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_if.sv
// Result port of spike_rate_decoder: packed rate words with a valid/ready handshake
// and the sticky overrun flag that travels with them.
interface spike_rate_if #(
    parameter int NCH   = 2,
    parameter int OUT_W = 12
);
    logic [NCH*OUT_W-1:0] rate_out;
    logic                 rate_valid;
    logic                 rate_ready;
    logic                 overrun;

    modport master (output rate_out, output rate_valid, output overrun, input rate_ready);
    modport slave  (input rate_out, input rate_valid, input overrun, output rate_ready);
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes per channel over 2**CNT_W enabled cycles and publishes scaled rates.
// Optional first-order smoothing of published rates: define SPIKE_DECODER_IIR_EN.
//
// state | meaning
// IDLE  | after reset, nothing counted yet
// COUNT | last cycle was enabled; counters advancing
// PAUSE | en low; counters held, spikes ignored
module spike_rate_decoder #(
    parameter int NCH   = 2,
    parameter int CNT_W = 8,
    parameter int OUT_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NCH-1:0]     spike_in,
    output logic               win_active,
    spike_rate_if.master       rate_if
);

    typedef enum logic [1:0] {IDLE, COUNT, PAUSE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     win_cnt;
    logic [CNT_W:0]       ch_cnt   [NCH];
    logic [CNT_W:0]       fin_cnt  [NCH];
    logic [CNT_W-1:0]     sat_cnt  [NCH];
    logic [OUT_W-1:0]     scaled   [NCH];
    logic                 win_close;
    logic [NCH*OUT_W-1:0] rate_next;

`ifdef SPIKE_DECODER_IIR_EN
    logic signed [OUT_W:0] iir_diff [NCH];
    logic signed [OUT_W:0] iir_sum  [NCH];
`endif

    // Every enabled cycle is counted regardless of state, so the FSM only tracks win_active.
    assign win_close = en && (win_cnt == {CNT_W{1'b1}});

    always_comb begin
        fin_cnt   = '{default: '0};
        sat_cnt   = '{default: '0};
        scaled    = '{default: '0};
        rate_next = '0;
`ifdef SPIKE_DECODER_IIR_EN
        iir_diff  = '{default: '0};
        iir_sum   = '{default: '0};
`endif
        for (int i = 0; i < NCH; i++) begin
            // The closing cycle's spike belongs to the window, so it can reach WIN_LEN.
            fin_cnt[i] = ch_cnt[i] + (CNT_W+1)'(spike_in[i]);
            sat_cnt[i] = fin_cnt[i][CNT_W] ? {CNT_W{1'b1}} : fin_cnt[i][CNT_W-1:0];
            scaled[i]  = OUT_W'(sat_cnt[i]) << (OUT_W - CNT_W);
`ifdef SPIKE_DECODER_IIR_EN
            iir_diff[i] = $signed({1'b0, scaled[i]})
                        - $signed({1'b0, rate_if.rate_out[i*OUT_W +: OUT_W]});
            iir_sum[i]  = $signed({1'b0, rate_if.rate_out[i*OUT_W +: OUT_W]})
                        + (iir_diff[i] >>> 2);
            rate_next[i*OUT_W +: OUT_W] = OUT_W'(iir_sum[i]);
`else
            rate_next[i*OUT_W +: OUT_W] = scaled[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            win_active         <= 1'b0;
            win_cnt            <= '0;
            for (int i = 0; i < NCH; i++) ch_cnt[i] <= '0;
            rate_if.rate_out   <= '0;
            rate_if.rate_valid <= 1'b0;
            rate_if.overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    state      <= COUNT;
                    win_active <= 1'b1;
                end
                COUNT: if (!en) begin
                    state      <= PAUSE;
                    win_active <= 1'b0;
                end
                PAUSE: if (en) begin
                    state      <= COUNT;
                    win_active <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    win_active <= 1'b0;
                end
            endcase

            if (en) begin
                if (win_close) begin
                    win_cnt <= '0;
                    for (int i = 0; i < NCH; i++) ch_cnt[i] <= '0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    for (int i = 0; i < NCH; i++) ch_cnt[i] <= fin_cnt[i];
                end
            end

            // A new result wins over a same-cycle transfer; only an unaccepted result is an overrun.
            if (win_close) begin
                rate_if.rate_out   <= rate_next;
                rate_if.rate_valid <= 1'b1;
                if (rate_if.rate_valid && !rate_if.rate_ready)
                    rate_if.overrun <= 1'b1;
            end else if (rate_if.rate_valid && rate_if.rate_ready) begin
                rate_if.rate_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: full rate, quarter rate, pause, overrun, reset mid-window.
module tb_spike_rate_decoder;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;
    localparam int OUT_W = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic [NCH-1:0] spike_in = '0;
    logic           win_active;

    int n_checks = 0;
    int n_errors = 0;
    int phase    = 0;
    int prev_rate [NCH];

    spike_rate_if #(.NCH(NCH), .OUT_W(OUT_W)) rate_if ();

    spike_rate_decoder #(.NCH(NCH), .CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .win_active (win_active),
        .rate_if    (rate_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ch_rate(input int ch);
        return int'(rate_if.rate_out[ch*OUT_W +: OUT_W]);
    endfunction

    // Expected published value for a window whose scaled count is given.
    function automatic int pub(input int ch, input int scaled_val);
`ifdef SPIKE_DECODER_IIR_EN
        int d;
        d = scaled_val - prev_rate[ch];
        prev_rate[ch] = (prev_rate[ch] + (d >>> 2)) & ((1 << OUT_W) - 1);
`else
        prev_rate[ch] = scaled_val;
`endif
        return prev_rate[ch];
    endfunction

    // Drive n cycles; channel c spikes when phase % per_c == 0 (per 0 = silent).
    task automatic run(input int n, input int per0, input int per1);
        for (int k = 0; k < n; k++) begin
            spike_in[0] = (per0 != 0) && (phase % per0 == 0);
            spike_in[1] = (per1 != 0) && (phase % per1 == 0);
            @(posedge clk);
            #1;
            phase++;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        spike_in = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        en    = 1'b1;
        phase = 0;
        for (int c = 0; c < NCH; c++) prev_rate[c] = 0;
    endtask

    initial begin
        rate_if.rate_ready = 1'b1;
        do_reset();
        check("rst_rate",    int'(rate_if.rate_out), 0);
        check("rst_valid",   int'(rate_if.rate_valid), 0);
        check("rst_overrun", int'(rate_if.overrun), 0);
        check("rst_active",  int'(win_active), 0);

        // Full rate on ch0, two windows.
        run(255, 1, 0);
        check("full_early_valid", int'(rate_if.rate_valid), 0);
        check("full_active",      int'(win_active), 1);
        run(1, 1, 0);
        check("full_valid", int'(rate_if.rate_valid), 1);
        check("full_ch0",   ch_rate(0), pub(0, 4080));
        check("full_ch1",   ch_rate(1), pub(1, 0));
        run(1, 1, 0);
        check("full_valid_drop", int'(rate_if.rate_valid), 0);
        run(255, 1, 0);
        check("full2_valid", int'(rate_if.rate_valid), 1);
        check("full2_ch0",   ch_rate(0), pub(0, 4080));

        // Quarter rate on ch1, with a transfer coinciding with the second close.
        do_reset();
        run(256, 0, 4);
        check("qtr1_valid", int'(rate_if.rate_valid), 1);
        check("qtr1_ch0",   ch_rate(0), pub(0, 0));
        check("qtr1_ch1",   ch_rate(1), pub(1, 1024));
        rate_if.rate_ready = 1'b0;
        run(255, 0, 4);
        check("qtr_hold_valid", int'(rate_if.rate_valid), 1);
        check("qtr_hold_ch1",   ch_rate(1), prev_rate[1]);
        rate_if.rate_ready = 1'b1;
        run(1, 0, 4);
        check("qtr2_valid",   int'(rate_if.rate_valid), 1);
        check("qtr2_overrun", int'(rate_if.overrun), 0);
        check("qtr2_ch1",     ch_rate(1), pub(1, 1024));
        run(1, 0, 4);
        check("qtr2_drop", int'(rate_if.rate_valid), 0);
        run(255, 0, 4);
        check("qtr3_valid", int'(rate_if.rate_valid), 1);
        check("qtr3_ch1",   ch_rate(1), pub(1, 1024));

        // Pause: spikes during en=0 must be ignored (ch1 only spikes then).
        do_reset();
        run(100, 1, 0);
        check("pause_active_on", int'(win_active), 1);
        en = 1'b0;
        run(50, 1, 1);
        check("pause_active_off", int'(win_active), 0);
        check("pause_no_valid",   int'(rate_if.rate_valid), 0);
        en = 1'b1;
        run(155, 1, 0);
        check("pause_early_valid", int'(rate_if.rate_valid), 0);
        run(1, 1, 0);
        check("pause_valid", int'(rate_if.rate_valid), 1);
        check("pause_ch0",   ch_rate(0), pub(0, 4080));
        check("pause_ch1",   ch_rate(1), pub(1, 0));

        // Overrun across two closes with the consumer stalled.
        do_reset();
        rate_if.rate_ready = 1'b0;
        run(256, 2, 0);
        check("ovr1_valid",   int'(rate_if.rate_valid), 1);
        check("ovr1_overrun", int'(rate_if.overrun), 0);
        check("ovr1_ch0",     ch_rate(0), pub(0, 2048));
        run(256, 8, 0);
        check("ovr2_valid",   int'(rate_if.rate_valid), 1);
        check("ovr2_overrun", int'(rate_if.overrun), 1);
        check("ovr2_ch0",     ch_rate(0), pub(0, 512));
        rate_if.rate_ready = 1'b1;
        run(1, 8, 0);
        rate_if.rate_ready = 1'b0;
        check("ovr_drop_valid", int'(rate_if.rate_valid), 0);
        check("ovr_sticky",     int'(rate_if.overrun), 1);

        // Reset mid-window with a pending result and partial counts.
        do_reset();
        run(256 + 130, 1, 0);
        check("mid_pre_valid", int'(rate_if.rate_valid), 1);
        check("mid_pre_ch0",   ch_rate(0), pub(0, 4080));
        rst = 1'b1;
        run(1, 1, 0);
        check("mid_rst_rate",    int'(rate_if.rate_out), 0);
        check("mid_rst_valid",   int'(rate_if.rate_valid), 0);
        check("mid_rst_overrun", int'(rate_if.overrun), 0);
        check("mid_rst_active",  int'(win_active), 0);
        rst   = 1'b0;
        phase = 0;
        for (int c = 0; c < NCH; c++) prev_rate[c] = 0;
        run(255, 2, 0);
        check("mid_early_valid", int'(rate_if.rate_valid), 0);
        run(1, 2, 0);
        check("mid_valid", int'(rate_if.rate_valid), 1);
        check("mid_ch0",   ch_rate(0), pub(0, 2048));
        check("mid_ch1",   ch_rate(1), pub(1, 0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
